wptr_full_ctrl: RTL

Write-domain pointer and flag controller for the parameterized async FIFO.
- Advances the write pointer on accepted writes and publishes it as Gray code. That Gray pointer is the d_in to the read-domain 2-FF synchronizer.
- Consumes the already-synchronized read Gray pointer to produce full, almost_full, a fill level and a sticky overflow flag.
- Sits between the write-side user interface, the dual-port memory write port, and the pointer synchronizers.

---
 rtl/async_fifo_pkg.sv | 24 ++
 rtl/wptr_full_ctrl.sv | 63 ++++++
 2 files changed

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer controllers (write-side full and read-side empty).
// Gray conversions work on a wide vector; callers size-cast to their own pointer width.
package async_fifo_pkg;

    localparam int FIFO_PTR_WIDTH = 4;
    localparam int GRAY_MAX_W     = 32;

    typedef logic [FIFO_PTR_WIDTH:0] ptr_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and flag controller for the async FIFO: advances the write pointer,
// publishes it in Gray code and derives full/almost_full/level/overflow from the synced read pointer.
module wptr_full_ctrl
    import async_fifo_pkg::*;
#(
    parameter int PTR_WIDTH = FIFO_PTR_WIDTH,
    parameter int AF_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 w_en,
    input  logic [PTR_WIDTH:0]   rptr_gray_sync,
    input  logic                 ovf_clr,
    output logic                 wr_accept,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH:0]   wptr_bin,
    output logic [PTR_WIDTH:0]   wptr_gray,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wr_level,
    output logic                 overflow
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PW-1:0] AF_THRESH = PW'((2 ** PTR_WIDTH) - AF_MARGIN);

    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_gray;
    logic [PW-1:0] level_next;

    // Acceptance looks only at the registered full flag, keeping rptr_gray_sync off any output path.
    assign wr_accept  = w_en & ~full & rstn;
    assign waddr      = wptr_bin[PTR_WIDTH-1:0];

    assign wbin_next  = wptr_bin + PW'(wr_accept);
    assign wgray_next = PW'(bin2gray(GRAY_MAX_W'(wbin_next)));
    assign rbin       = PW'(gray2bin(GRAY_MAX_W'(rptr_gray_sync)));
    assign level_next = wbin_next - rbin;

    // Full in Gray space: read pointer one lap behind shows up as the top two bits inverted.
    assign full_gray  = {~rptr_gray_sync[PW-1:PW-2], rptr_gray_sync[PW-3:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_bin    <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wptr_bin    <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= (wgray_next == full_gray);
            almost_full <= (level_next >= AF_THRESH);
            wr_level    <= level_next;
            overflow    <= (w_en & full) | (overflow & ~ovf_clr);
        end
    end

endmodule
